// File: rtl/loop_branch_sequencer.sv
// Loop/branch issue sequencer: fetches 9-bit counter/branch ops over valid/ready,
// executes them against a 4-entry loop-counter file and an 8-bit PC.
module loop_branch_sequencer #(
   parameter logic [7:0] RESET_PC  = 8'h00,
   parameter int         ZERO_JUMP = 16,
   parameter int         TIMEOUT   = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic [7:0] instr_addr,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic [8:0] instr,
   input  logic       wr_en,
   input  logic [1:0] wr_idx,
   input  logic [7:0] wr_data,
   input  logic [1:0] rd_idx,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic       done,
   output logic       fault
);

   typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

   typedef struct packed {
      logic [2:0] op;
      logic [1:0] idx;
      logic [2:0] v;
   } instr_t;

   localparam logic [2:0] OP_INCR = 3'b001;
   localparam logic [2:0] OP_DECR = 3'b010;
   localparam logic [2:0] OP_JIZR = 3'b011;
   localparam logic [2:0] OP_JNZR = 3'b100;
   localparam logic [2:0] OP_HALT = 3'b111;

   localparam logic [7:0] ZJ      = ZERO_JUMP[7:0];
   localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

   state_t          state, state_n;
   logic [7:0]      pc;
   logic [3:0][7:0] regs;
   instr_t          ir;
   logic [3:0]      wcnt;
   logic            fault_q;

   // Bit 0 of the instruction word is reserved and deliberately not decoded.
   logic unused_rsvd;
   assign unused_rsvd = instr[0];

   // EXEC datapath: branch condition reads the register before any update.
   logic [7:0] r_cur, offset, pc_nx, reg_nx;
   logic       reg_wr;

   always_comb begin
      r_cur  = regs[ir.idx];
      offset = (ir.v != 3'd0) ? {4'b0000, ir.v, 1'b0} : ZJ;
      pc_nx  = pc + 8'd1;
      reg_nx = r_cur;
      reg_wr = 1'b0;
      case (ir.op)
         OP_INCR: begin reg_nx = r_cur + 8'd1; reg_wr = 1'b1; end
         OP_DECR: begin reg_nx = r_cur - 8'd1; reg_wr = 1'b1; end
         OP_JIZR: if (r_cur == 8'd0) pc_nx = pc + offset;
         OP_JNZR: if (r_cur != 8'd0) pc_nx = pc + offset;
         OP_HALT: pc_nx = pc;
         default: ;
      endcase
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE, DONE: if (start) state_n = FETCH;
         FETCH: begin
            if (instr_valid)          state_n = EXEC;
            else if (wcnt == TO_LAST) state_n = DONE;
         end
         EXEC:    state_n = (ir.op == OP_HALT) ? DONE : FETCH;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc      <= RESET_PC;
         regs    <= '0;
         ir      <= '0;
         wcnt    <= '0;
         fault_q <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               // start takes priority; a same-cycle host write is dropped
               if (start) begin
                  pc      <= RESET_PC;
                  fault_q <= 1'b0;
                  wcnt    <= '0;
               end else if (wr_en) begin
                  regs[wr_idx] <= wr_data;
               end
            end
            FETCH: begin
               if (instr_valid) begin
                  ir <= instr_t'(instr[8:1]);
               end else begin
                  wcnt <= wcnt + 4'd1;
                  if (wcnt == TO_LAST) fault_q <= 1'b1;
               end
            end
            EXEC: begin
               pc   <= pc_nx;
               wcnt <= '0;
               if (reg_wr) regs[ir.idx] <= reg_nx;
            end
            default: ;
         endcase
      end
   end

   assign instr_addr  = pc;
   assign instr_ready = (state == FETCH);
   assign busy        = (state == FETCH) || (state == EXEC);
   assign done        = (state == DONE);
   assign fault       = fault_q;
   assign rd_data     = regs[rd_idx];

endmodule

// File: tb/tb_loop_branch_sequencer.sv
// Directed bench for loop_branch_sequencer: each task drives one scenario and checks inline.
module tb_loop_branch_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] instr_addr;
   logic       instr_valid;
   logic       instr_ready;
   logic [8:0] instr;
   logic       wr_en;
   logic [1:0] wr_idx;
   logic [7:0] wr_data;
   logic [1:0] rd_idx;
   logic [7:0] rd_data;
   logic       busy, done, fault;

   int total  = 0;
   int passed = 0;

   localparam logic [8:0] I_NOP      = 9'b000_00_000_0;
   localparam logic [8:0] I_NOP5     = 9'b101_00_000_0;
   localparam logic [8:0] I_HALT     = 9'b111_00_000_0;
   localparam logic [8:0] I_DECR_R1  = 9'b010_01_000_0;
   localparam logic [8:0] I_JNZR_R1  = 9'b100_01_111_0;
   localparam logic [8:0] I_JIZR_R0  = 9'b011_00_000_0;
   localparam logic [8:0] I_JIZR_R04 = 9'b011_00_100_0;
   localparam logic [8:0] I_JNZR_R0  = 9'b100_00_000_0;
   localparam logic [8:0] I_JNZR_R04 = 9'b100_00_100_0;
   localparam logic [8:0] I_INCR_R2  = 9'b001_10_000_0;
   localparam logic [8:0] I_DECR_R2R = 9'b010_10_000_1;
   localparam logic [8:0] I_INCR_R3  = 9'b001_11_000_0;

   loop_branch_sequencer dut (
      .clk(clk), .reset(reset), .start(start),
      .instr_addr(instr_addr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
      .rd_idx(rd_idx), .rd_data(rd_data),
      .busy(busy), .done(done), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic host_wr(input logic [1:0] idx, input logic [7:0] data);
      wr_en = 1'b1; wr_idx = idx; wr_data = data;
      tick();
      wr_en = 1'b0;
   endtask

   // Handshake one instruction (DUT sits in FETCH), then let EXEC complete.
   task automatic issue(input logic [8:0] ins);
      instr_valid = 1'b1; instr = ins;
      tick();
      instr_valid = 1'b0; instr = 9'h1AA;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) tick();
      total++; if ({instr_ready, busy, done, fault} !== 4'b0000)
         $display("FAIL reset_flags: got %b want 0000", {instr_ready, busy, done, fault}); else passed++;
      total++; if (instr_addr !== 8'h00)
         $display("FAIL reset_pc: got %h want 00", instr_addr); else passed++;
      reset = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         rd_idx = 2'(k); #1;
         total++; if (rd_data !== 8'h00)
            $display("FAIL reset_reg%0d: got %h want 00", k, rd_data); else passed++;
      end
   endtask

   task automatic test_loop();
      host_wr(2'd1, 8'h03);
      rd_idx = 2'd1; #1;
      total++; if (rd_data !== 8'h03)
         $display("FAIL loop_wr: got %h want 03", rd_data); else passed++;
      pulse_start();
      total++; if ({instr_ready, busy, instr_addr} !== {2'b11, 8'h00})
         $display("FAIL loop_start: got rdy/busy/pc %b%b %h want 11 00", instr_ready, busy, instr_addr); else passed++;
      for (int i = 0; i < 3; i++) begin
         issue(I_DECR_R1);
         total++; if ({rd_data, instr_addr} !== {8'(2 - i), 8'h01})
            $display("FAIL loop_decr%0d: got r1=%h pc=%h want r1=%h pc=01", i, rd_data, instr_addr, 8'(2 - i)); else passed++;
         issue(I_JNZR_R1);
         if (i < 2) begin
            total++; if (instr_addr !== 8'h0F)
               $display("FAIL loop_taken%0d: got %h want 0f", i, instr_addr); else passed++;
            issue(I_HALT);
            total++; if ({done, instr_addr} !== {1'b1, 8'h0F})
               $display("FAIL loop_halt%0d: got done=%b pc=%h want 1 0f", i, done, instr_addr); else passed++;
            pulse_start();
         end else begin
            total++; if ({busy, instr_addr} !== {1'b1, 8'h02})
               $display("FAIL loop_fall: got busy=%b pc=%h want 1 02", busy, instr_addr); else passed++;
         end
      end
      issue(I_HALT);
   endtask

   task automatic test_zero_jump();
      rd_idx = 2'd0;
      pulse_start();
      for (int i = 0; i < 15; i++) issue(I_JIZR_R0);
      total++; if (instr_addr !== 8'hF0)
         $display("FAIL zj_walk: got %h want f0", instr_addr); else passed++;
      issue(I_JIZR_R04);
      total++; if (instr_addr !== 8'hF8)
         $display("FAIL zj_v4: got %h want f8", instr_addr); else passed++;
      issue(I_JIZR_R0);
      total++; if (instr_addr !== 8'h08)
         $display("FAIL zj_wrap: got %h want 08", instr_addr); else passed++;
      issue(I_NOP5);
      total++; if (instr_addr !== 8'h09)
         $display("FAIL zj_nop5: got %h want 09", instr_addr); else passed++;
      issue(I_HALT);
      host_wr(2'd0, 8'h05);
      pulse_start();
      for (int i = 0; i < 15; i++) issue(I_JNZR_R0);
      issue(I_JNZR_R04);
      total++; if (instr_addr !== 8'hF8)
         $display("FAIL zj_walk2: got %h want f8", instr_addr); else passed++;
      issue(I_JIZR_R0);
      total++; if ({instr_addr, rd_data} !== {8'hF9, 8'h05})
         $display("FAIL zj_nottaken: got pc=%h r0=%h want f9 05", instr_addr, rd_data); else passed++;
      issue(I_HALT);
   endtask

   task automatic test_wrap();
      host_wr(2'd2, 8'hFF);
      rd_idx = 2'd2;
      pulse_start();
      issue(I_INCR_R2);
      total++; if ({rd_data, instr_addr} !== {8'h00, 8'h01})
         $display("FAIL wrap_incr: got r2=%h pc=%h want 00 01", rd_data, instr_addr); else passed++;
      pulse_start();
      total++; if ({busy, instr_addr} !== {1'b1, 8'h01})
         $display("FAIL start_busy: got busy=%b pc=%h want 1 01", busy, instr_addr); else passed++;
      issue(I_DECR_R2R);
      total++; if ({rd_data, instr_addr} !== {8'hFF, 8'h02})
         $display("FAIL wrap_decr: got r2=%h pc=%h want ff 02", rd_data, instr_addr); else passed++;
      issue(I_HALT);
   endtask

   task automatic test_timeout();
      pulse_start();
      repeat (14) tick();
      total++; if ({busy, fault, instr_addr} !== {2'b10, 8'h00})
         $display("FAIL to_before: got busy=%b fault=%b pc=%h want 1 0 00", busy, fault, instr_addr); else passed++;
      tick();
      total++; if ({fault, done, busy, instr_ready} !== 4'b1100)
         $display("FAIL to_fault: got f/d/b/r=%b want 1100", {fault, done, busy, instr_ready}); else passed++;
      pulse_start();
      total++; if ({fault, busy, instr_addr} !== {2'b01, 8'h00})
         $display("FAIL to_restart: got fault=%b busy=%b pc=%h want 0 1 00", fault, busy, instr_addr); else passed++;
   endtask

   task automatic test_halt_wr();
      rd_idx = 2'd3;
      issue(I_NOP);
      host_wr(2'd3, 8'hAA);
      total++; if (rd_data !== 8'h00)
         $display("FAIL wr_busy: got r3=%h want 00", rd_data); else passed++;
      issue(I_HALT);
      tick(); tick();
      total++; if ({done, busy, instr_addr} !== {2'b10, 8'h01})
         $display("FAIL halt_hold: got done=%b busy=%b pc=%h want 1 0 01", done, busy, instr_addr); else passed++;
      start = 1'b1; wr_en = 1'b1; wr_idx = 2'd3; wr_data = 8'h55;
      tick();
      start = 1'b0; wr_en = 1'b0;
      total++; if ({rd_data, busy, instr_addr} !== {8'h00, 1'b1, 8'h00})
         $display("FAIL wr_start: got r3=%h busy=%b pc=%h want 00 1 00", rd_data, busy, instr_addr); else passed++;
   endtask

   task automatic test_reset_exec();
      issue(I_INCR_R3);
      total++; if ({rd_data, instr_addr} !== {8'h01, 8'h01})
         $display("FAIL rx_incr: got r3=%h pc=%h want 01 01", rd_data, instr_addr); else passed++;
      instr_valid = 1'b1; instr = I_INCR_R3;
      tick();
      instr_valid = 1'b0;
      total++; if ({busy, instr_ready} !== 2'b10)
         $display("FAIL rx_exec: got busy=%b rdy=%b want 1 0", busy, instr_ready); else passed++;
      reset = 1'b1; #1;
      for (int k = 0; k < 4; k++) begin
         rd_idx = 2'(k); #1;
         total++; if (rd_data !== 8'h00)
            $display("FAIL rx_reg%0d: got %h want 00", k, rd_data); else passed++;
      end
      total++; if ({instr_addr, instr_ready, busy, done, fault} !== {8'h00, 4'b0000})
         $display("FAIL rx_outs: got pc=%h flags=%b want 00 0000", instr_addr, {instr_ready, busy, done, fault}); else passed++;
      tick();
      reset = 1'b0;
      tick(); tick();
      total++; if ({busy, done, instr_addr} !== {2'b00, 8'h00})
         $display("FAIL rx_idle: got busy=%b done=%b pc=%h want 0 0 00", busy, done, instr_addr); else passed++;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; instr_valid = 1'b0; instr = '0;
      wr_en = 1'b0; wr_idx = '0; wr_data = '0; rd_idx = '0;
      test_reset();
      test_loop();
      test_zero_jump();
      test_wrap();
      test_timeout();
      test_halt_wr();
      test_reset_exec();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
